// File: rtl/nec_pkg.sv
// rtl/nec_pkg.sv - shared states, timing windows and frame layout for the NEC IR decoder
package nec_pkg;

    // Duration and gap counters share this width; both saturate at CNT_MAX.
    localparam int               CNT_W   = 17;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Inclusive duration windows in microseconds.
    localparam logic [CNT_W-1:0] LEAD_MARK_MIN  = 17'd8000;
    localparam logic [CNT_W-1:0] LEAD_MARK_MAX  = 17'd10000;
    localparam logic [CNT_W-1:0] LEAD_SPACE_MIN = 17'd4000;
    localparam logic [CNT_W-1:0] LEAD_SPACE_MAX = 17'd5000;
    localparam logic [CNT_W-1:0] REP_SPACE_MIN  = 17'd2000;
    localparam logic [CNT_W-1:0] REP_SPACE_MAX  = 17'd2500;
    localparam logic [CNT_W-1:0] BIT_MARK_MIN   = 17'd400;
    localparam logic [CNT_W-1:0] BIT_MARK_MAX   = 17'd750;
    localparam logic [CNT_W-1:0] ZERO_SPACE_MIN = 17'd400;
    localparam logic [CNT_W-1:0] ZERO_SPACE_MAX = 17'd750;
    localparam logic [CNT_W-1:0] ONE_SPACE_MIN  = 17'd1400;
    localparam logic [CNT_W-1:0] ONE_SPACE_MAX  = 17'd1900;

    // Byte positions inside the 32-bit frame (first received byte is byte 0).
    localparam logic [1:0] B_ADDR   = 2'd0;
    localparam logic [1:0] B_ADDR_N = 2'd1;
    localparam logic [1:0] B_CMD    = 2'd2;
    localparam logic [1:0] B_CMD_N  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_REP_MARK
    } nec_state_t;

    function automatic logic in_win(input logic [CNT_W-1:0] d,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [31:0] f, input logic [1:0] idx);
        return f[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/nec_edge_filter.sv
// rtl/nec_edge_filter.sv - IR pin synchroniser, polarity fix, glitch filter and edge pulses
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_ir         raw asynchronous IR pin
//   o_rise       one-cycle pulse when the filtered level goes space -> mark
//   o_fall       one-cycle pulse when the filtered level goes mark -> space
module nec_edge_filter #(
    parameter int GLITCH_CYC = 8,
    parameter int INVERT_IN  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ir,
    output logic o_rise,
    output logic o_fall
);

    localparam int   GW       = $clog2(GLITCH_CYC + 1);
    // Synchroniser resets to the pin's idle level so reset release creates no edge.
    localparam logic IDLE_RAW = (INVERT_IN != 0) ? 1'b1 : 1'b0;

    logic          sync_a;
    logic          sync_b;
    logic          sample;
    logic          level;
    logic [GW-1:0] run_cnt;

    // Internally 1 = mark.
    assign sample = (INVERT_IN != 0) ? ~sync_b : sync_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= IDLE_RAW;
            sync_b  <= IDLE_RAW;
            level   <= 1'b0;
            run_cnt <= '0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            sync_a <= i_ir;
            sync_b <= sync_a;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            // run_cnt counts consecutive samples that disagree with the accepted level.
            if (sample == level) begin
                run_cnt <= '0;
            end else if (run_cnt == GW'(GLITCH_CYC - 1)) begin
                level   <= sample;
                run_cnt <= '0;
                o_rise  <= sample;
                o_fall  <= ~sample;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// rtl/nec_ir_decoder.sv - NEC IR frame/repeat decoder with single-entry valid/ready buffer
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_ir         raw IR receiver pin
//   i_ready      consumer takes the buffered entry when o_valid is high
//   o_valid      buffered entry present; o_address/o_command/o_repeat stable while high
//   o_address    {address_bar, address} (EXTENDED=1) or {8'h00, address}
//   o_command    command byte
//   o_repeat     buffered entry came from a repeat code
//   o_err        one-cycle pulse on malformed timing or failed check
//   o_overrun    one-cycle pulse when a completed entry is dropped
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int CLK_FREQ_MHZ  = 50,
    parameter int GLITCH_CYC    = 8,
    parameter int INVERT_IN     = 1,
    parameter int EXTENDED      = 0,
    parameter int REPEAT_WIN_US = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ir,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_address,
    output logic [7:0]  o_command,
    output logic        o_repeat,
    output logic        o_err,
    output logic        o_overrun
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    logic             rise;
    logic             fall;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      shreg;
    logic             have_last;
    logic [15:0]      last_addr;
    logic [7:0]       last_cmd;

    nec_state_t state;
    nec_state_t state_nx;
    logic       shift_en;
    logic       shift_bit;
    logic       bit_clr;
    logic       frame_end;
    logic       rep_end;
    logic       win_err;

    logic [7:0]  b_addr;
    logic [7:0]  b_addr_n;
    logic [7:0]  b_cmd;
    logic [7:0]  b_cmd_n;
    logic [15:0] frame_addr;
    logic        check_pass;
    logic        gap_ok;
    logic        frame_ok;
    logic        rep_ok;
    logic        accept;
    logic        fail;
    logic [15:0] new_addr;
    logic [7:0]  new_cmd;

    nec_edge_filter #(
        .GLITCH_CYC (GLITCH_CYC),
        .INVERT_IN  (INVERT_IN)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .i_ir   (i_ir),
        .o_rise (rise),
        .o_fall (fall)
    );

    // One tick per microsecond.
    assign tick = (pre_cnt == PW'(CLK_FREQ_MHZ - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Each duration is judged at the edge that ends it; dur_cnt still holds it then.
    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        bit_clr   = 1'b0;
        frame_end = 1'b0;
        rep_end   = 1'b0;
        win_err   = 1'b0;
        if (state != ST_IDLE && dur_cnt == CNT_MAX) begin
            win_err  = 1'b1;
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) state_nx = ST_LEAD_MARK;
                end
                ST_LEAD_MARK: begin
                    if (fall) begin
                        if (in_win(dur_cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                            state_nx = ST_LEAD_SPACE;
                        end else begin
                            win_err  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end
                end
                ST_LEAD_SPACE: begin
                    if (rise) begin
                        if (in_win(dur_cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            bit_clr  = 1'b1;
                            state_nx = ST_BIT_MARK;
                        end else if (in_win(dur_cnt, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                            state_nx = ST_REP_MARK;
                        end else begin
                            win_err  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end
                end
                ST_BIT_MARK: begin
                    if (fall) begin
                        if (in_win(dur_cnt, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                            state_nx = ST_BIT_SPACE;
                        end else begin
                            win_err  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end
                end
                ST_BIT_SPACE: begin
                    if (rise) begin
                        if (in_win(dur_cnt, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
                            shift_en = 1'b1;
                        end else if (in_win(dur_cnt, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                            shift_en  = 1'b1;
                            shift_bit = 1'b1;
                        end else begin
                            win_err  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                        if (shift_en) begin
                            state_nx = (bit_cnt == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                        end
                    end
                end
                ST_STOP_MARK: begin
                    if (fall) begin
                        if (in_win(dur_cnt, BIT_MARK_MIN, BIT_MARK_MAX)) frame_end = 1'b1;
                        else                                             win_err   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_REP_MARK: begin
                    if (fall) begin
                        if (in_win(dur_cnt, BIT_MARK_MIN, BIT_MARK_MAX)) rep_end = 1'b1;
                        else                                             win_err = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // The last shift lands before the stop mark, so shreg is complete at frame_end.
    assign b_addr     = frame_byte(shreg, B_ADDR);
    assign b_addr_n   = frame_byte(shreg, B_ADDR_N);
    assign b_cmd      = frame_byte(shreg, B_CMD);
    assign b_cmd_n    = frame_byte(shreg, B_CMD_N);
    assign check_pass = (b_cmd_n == ~b_cmd) && ((EXTENDED != 0) || (b_addr_n == ~b_addr));
    assign frame_addr = (EXTENDED != 0) ? {b_addr_n, b_addr} : {8'h00, b_addr};
    assign gap_ok     = ({15'd0, gap_cnt} <= 32'(REPEAT_WIN_US));

    assign frame_ok = frame_end & check_pass;
    assign rep_ok   = rep_end & have_last & gap_ok;
    assign accept   = frame_ok | rep_ok;
    assign fail     = win_err | (frame_end & ~check_pass) | (rep_end & ~rep_ok);
    assign new_addr = frame_ok ? frame_addr : last_addr;
    assign new_cmd  = frame_ok ? b_cmd : last_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            have_last <= 1'b0;
            last_addr <= '0;
            last_cmd  <= '0;
            o_valid   <= 1'b0;
            o_address <= '0;
            o_command <= '0;
            o_repeat  <= 1'b0;
            o_err     <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_err     <= fail;
            o_overrun <= 1'b0;

            if (rise || fall) begin
                dur_cnt <= '0;
            end else if (tick && dur_cnt != CNT_MAX) begin
                dur_cnt <= dur_cnt + 1'b1;
            end

            if (accept) begin
                gap_cnt <= '0;
            end else if (tick && gap_cnt != CNT_MAX) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // LSB first: the first received bit ends up in shreg[0].
            if (shift_en) shreg <= {shift_bit, shreg[31:1]};

            // Repeat memory tracks every good frame, even one dropped by overrun.
            if (fail) begin
                have_last <= 1'b0;
            end else if (frame_ok) begin
                have_last <= 1'b1;
                last_addr <= frame_addr;
                last_cmd  <= b_cmd;
            end

            if (accept) begin
                if (!o_valid || i_ready) begin
                    o_valid   <= 1'b1;
                    o_address <= new_addr;
                    o_command <= new_cmd;
                    o_repeat  <= rep_ok;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb/tb_nec_ir_decoder.sv - directed self-checking bench for nec_ir_decoder (strict and extended)
module tb_nec_ir_decoder;

    logic        clk;
    logic        rst;
    logic        ir;
    logic        rdy;
    logic        rdy_x;

    logic        d_valid, d_rep, d_err, d_ovr;
    logic [15:0] d_addr;
    logic [7:0]  d_cmd;
    logic        x_valid, x_rep, x_err, x_ovr;
    logic [15:0] x_addr;
    logic [7:0]  x_cmd;

    int errors = 0;
    int checks = 0;
    int n_err = 0;
    int n_err_x = 0;
    int n_ovr = 0;

    nec_ir_decoder #(
        .CLK_FREQ_MHZ(1), .GLITCH_CYC(4), .INVERT_IN(1), .EXTENDED(0), .REPEAT_WIN_US(120000)
    ) dut (
        .clk(clk), .rst(rst), .i_ir(ir), .i_ready(rdy),
        .o_valid(d_valid), .o_address(d_addr), .o_command(d_cmd),
        .o_repeat(d_rep), .o_err(d_err), .o_overrun(d_ovr)
    );

    nec_ir_decoder #(
        .CLK_FREQ_MHZ(1), .GLITCH_CYC(4), .INVERT_IN(1), .EXTENDED(1), .REPEAT_WIN_US(120000)
    ) dut_x (
        .clk(clk), .rst(rst), .i_ir(ir), .i_ready(rdy_x),
        .o_valid(x_valid), .o_address(x_addr), .o_command(x_cmd),
        .o_repeat(x_rep), .o_err(x_err), .o_overrun(x_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (d_err) n_err++;
        if (x_err) n_err_x++;
        if (d_ovr || x_ovr) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Active-low pin: mark drives 0.
    task automatic drive(input logic mark, input int n);
        ir = ~mark;
        wait_cyc(n);
    endtask

    task automatic send_leader(input logic glitch);
        if (glitch) begin
            drive(1'b1, 3000);
            drive(1'b0, 2);
            drive(1'b1, 3000);
            drive(1'b0, 2);
            drive(1'b1, 2996);
        end else begin
            drive(1'b1, 9000);
        end
        drive(1'b0, 4500);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, 560);
        drive(1'b0, b ? 1690 : 560);
    endtask

    // Returns right after the pin edge that ends the stop mark.
    task automatic send_frame(input logic [31:0] data, input logic glitch);
        send_leader(glitch);
        for (int i = 0; i < 32; i++) send_bit(data[i]);
        drive(1'b1, 560);
        ir = 1'b1;
    endtask

    task automatic send_repeat();
        drive(1'b1, 9000);
        drive(1'b0, 2250);
        drive(1'b1, 560);
        ir = 1'b1;
    endtask

    initial begin
        logic [31:0] part;
        ir    = 1'b1;
        rst   = 1'b1;
        rdy   = 1'b1;
        rdy_x = 1'b1;
        wait_cyc(5);
        check("rst_valid",   32'(d_valid), 32'h0);
        check("rst_address", 32'(d_addr),  32'h0);
        check("rst_command", 32'(d_cmd),   32'h0);
        check("rst_repeat",  32'(d_rep),   32'h0);
        check("rst_err",     32'(d_err),   32'h0);
        check("rst_overrun", 32'(d_ovr),   32'h0);
        rst = 1'b0;
        wait_cyc(20);

        // Strict frame 04 FB 08 F7 with 2-cycle glitches in the leader mark.
        send_frame(32'hF708FB04, 1'b1);
        wait_cyc(6);
        check("strict_not_early", 32'(d_valid), 32'h0);
        wait_cyc(1);
        check("strict_valid",   32'(d_valid), 32'h1);
        check("strict_address", 32'(d_addr),  32'h0004);
        check("strict_command", 32'(d_cmd),   32'h08);
        check("strict_repeat",  32'(d_rep),   32'h0);
        check("ext_valid",      32'(x_valid), 32'h1);
        check("ext_address",    32'(x_addr),  32'hFB04);
        wait_cyc(1);
        check("strict_popped",  32'(d_valid), 32'h0);

        // Repeat 40 ms later.
        wait_cyc(40000);
        send_repeat();
        wait_cyc(7);
        check("rep_valid",   32'(d_valid), 32'h1);
        check("rep_flag",    32'(d_rep),   32'h1);
        check("rep_address", 32'(d_addr),  32'h0004);
        check("rep_command", 32'(d_cmd),   32'h08);
        check("rep_ext_adr", 32'(x_addr),  32'hFB04);

        // Bad command_bar.
        wait_cyc(1000);
        send_frame(32'hF608FB04, 1'b0);
        wait_cyc(7);
        check("badcmd_err",   32'(d_err),   32'h1);
        check("badcmd_valid", 32'(d_valid), 32'h0);
        check("badcmd_x_err", 32'(x_err),   32'h1);

        // Repeat soon after: rejected because have_last was cleared.
        wait_cyc(1000);
        send_repeat();
        wait_cyc(7);
        check("rep_nolast_err",   32'(d_err),   32'h1);
        check("rep_nolast_valid", 32'(d_valid), 32'h0);
        check("rep_nolast_x_err", 32'(x_err),   32'h1);

        // 34 12 08 F7: extended accepts, strict rejects.
        wait_cyc(1000);
        send_frame(32'hF7081234, 1'b0);
        wait_cyc(7);
        check("ext_strict_err", 32'(d_err),   32'h1);
        check("ext_valid2",     32'(x_valid), 32'h1);
        check("ext_address2",   32'(x_addr),  32'h1234);
        check("ext_command2",   32'(x_cmd),   32'h08);

        // Repeat 130 ms after the last accepted frame.
        wait_cyc(130000);
        send_repeat();
        wait_cyc(7);
        check("rep_late_x_err",   32'(x_err),   32'h1);
        check("rep_late_x_valid", 32'(x_valid), 32'h0);

        // Backpressure: first frame held, second dropped.
        wait_cyc(1000);
        rdy = 1'b0;
        send_frame(32'hF708FB04, 1'b0);
        wait_cyc(7);
        check("bp1_valid",   32'(d_valid), 32'h1);
        check("bp1_command", 32'(d_cmd),   32'h08);
        wait_cyc(1000);
        send_frame(32'hEF10FB04, 1'b0);
        wait_cyc(7);
        check("bp2_overrun", 32'(d_ovr),   32'h1);
        check("bp2_valid",   32'(d_valid), 32'h1);
        check("bp2_held",    32'(d_cmd),   32'h08);
        wait_cyc(1);
        check("bp2_ovr_pulse", 32'(d_ovr), 32'h0);

        // Ready raised exactly in the completion cycle.
        wait_cyc(1000);
        send_frame(32'hDF20FB04, 1'b0);
        wait_cyc(6);
        check("bp3_pre_cmd", 32'(d_cmd), 32'h08);
        rdy = 1'b1;
        wait_cyc(1);
        check("bp3_valid",   32'(d_valid), 32'h1);
        check("bp3_command", 32'(d_cmd),   32'h20);
        check("bp3_no_ovr",  32'(d_ovr),   32'h0);
        rdy = 1'b0;
        wait_cyc(1);
        check("bp3_held", 32'(d_valid), 32'h1);

        // Reset during bit 10 with an entry still buffered.
        wait_cyc(1000);
        part = 32'hF708FB04;
        send_leader(1'b0);
        for (int i = 0; i < 10; i++) send_bit(part[i]);
        drive(1'b1, 560);
        ir = 1'b1;
        wait_cyc(100);
        rst = 1'b1;
        wait_cyc(3);
        check("midrst_valid",   32'(d_valid), 32'h0);
        check("midrst_command", 32'(d_cmd),   32'h0);
        check("midrst_address", 32'(d_addr),  32'h0);
        rst = 1'b0;
        rdy = 1'b1;
        wait_cyc(2000);
        check("midrst_no_err", 32'(n_err), 32'd4);

        send_frame(32'hF708FB04, 1'b0);
        wait_cyc(7);
        check("postrst_valid",   32'(d_valid), 32'h1);
        check("postrst_address", 32'(d_addr),  32'h0004);
        check("postrst_command", 32'(d_cmd),   32'h08);

        wait_cyc(10);
        check("total_err",   32'(n_err),   32'd4);
        check("total_err_x", 32'(n_err_x), 32'd3);
        check("total_ovr",   32'(n_ovr),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
